// File: rtl/trivium_stream_decryptor.sv
// Keystream consumer for a trivium generator: packs serial keystream bits LSB-first into
// DATA_W-bit words and XORs each word with one valid/ready input word (decrypts or encrypts).
module trivium_stream_decryptor #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ks_en,
    input  logic              ks_warm_up_complete,
    input  logic              ks_bit,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_WARMUP,
        S_FILL,
        S_HOLD
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] ks_word_q;
    logic [DATA_W-1:0] m_data_q;
    logic              m_valid_q;
    logic              accept;

    // Generator is paused while a full keystream word waits in HOLD, so no bit is ever lost.
    assign ks_en   = rst && (state_q != S_HOLD);
    assign s_ready = rst && (state_q == S_HOLD) && (!m_valid_q || m_ready);
    assign busy    = rst && !((state_q == S_HOLD) && !m_valid_q);
    assign accept  = s_valid && s_ready;
    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;

    // NOTE: every register below is assigned with <= so all reads see pre-edge values,
    // which lets the HOLD accept consume ks_word_q even when a re-key clears it on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_WARMUP;
            bit_cnt_q <= '0;
            ks_word_q <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                m_data_q  <= s_data ^ ks_word_q;
                m_valid_q <= 1'b1;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end

            // Losing warm-up means the generator was re-keyed: any partial word is stale.
            if (state_q != S_WARMUP && !ks_warm_up_complete) begin
                state_q   <= S_WARMUP;
                bit_cnt_q <= '0;
                ks_word_q <= '0;
            end else begin
                case (state_q)
                    S_WARMUP: begin
                        if (ks_warm_up_complete) state_q <= S_FILL;
                    end
                    S_FILL: begin
                        ks_word_q[bit_cnt_q] <= ks_bit;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            state_q   <= S_HOLD;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (accept) state_q <= S_FILL;
                    end
                    default: state_q <= S_WARMUP;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trivium_stream_decryptor.sv
// Scoreboard bench for trivium_stream_decryptor using a stub keystream generator whose bit
// sequence is chosen by the bench; expected words are derived from that sequence directly.
module tb_trivium_stream_decryptor;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              ks_en;
    logic              wuc;
    logic              ks_bit;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              busy;

    bit                ks_arr [0:1023];
    int                gen_idx = 0;
    bit                rekey;
    int                tests = 0;
    int                fails = 0;
    logic [DATA_W-1:0] exp_q [$];
    int                word_k = 0;
    int                cyc = 0;

    always #5 clk = ~clk;

    // Stub generator: advances one bit on every edge where it is enabled and warmed up.
    always @(posedge clk) begin
        if (rekey) gen_idx <= 0;
        else if (ks_en && wuc) gen_idx <= gen_idx + 1;
    end
    assign ks_bit = ks_arr[gen_idx];

    trivium_stream_decryptor #(.DATA_W(DATA_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ks_en               (ks_en),
        .ks_warm_up_complete (wuc),
        .ks_bit              (ks_bit),
        .s_data              (s_data),
        .s_valid             (s_valid),
        .s_ready             (s_ready),
        .m_data              (m_data),
        .m_valid             (m_valid),
        .m_ready             (m_ready),
        .busy                (busy)
    );

    // The generator bit presented on the WARMUP->FILL edge is skipped (no bit taken in WARMUP),
    // after which each word is the next DATA_W bits of the sequence, LSB first.
    function automatic logic [DATA_W-1:0] model_word(int k);
        logic [DATA_W-1:0] w;
        for (int j = 0; j < DATA_W; j++) w[j] = ks_arr[1 + DATA_W * k + j];
        return w;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Inputs are already set at a falling edge; log any handshake that the next rising edge will take.
    task automatic step(output bit acc);
        #1;
        acc = s_valid && s_ready;
        if (acc) begin
            exp_q.push_back(s_data ^ model_word(word_k));
            word_k++;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until_accept(output int edges);
        bit acc;
        edges = 0;
        acc   = 1'b0;
        while (!acc && edges < 40) begin
            step(acc);
            if (!acc) edges++;
        end
    endtask

    initial begin : monitor
        logic [DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %0h expected none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("scoreboard", m_data, e);
                end
            end
        end
    end

    initial begin : stimulus
        bit acc;
        bit any_acc;
        int edges;
        int last_cyc;
        int n;

        rst = 1'b0; wuc = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; rekey = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            if (i <= 8) ks_arr[i] = 1'b1;
            else if (i <= 16) ks_arr[i] = ((i - 9) % 2 == 0);
            else ks_arr[i] = 1'($urandom_range(1));
        end

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ks_en", ks_en, 0);
            check("rst_s_ready", s_ready, 0);
            check("rst_m_valid", m_valid, 0);
            check("rst_m_data", m_data, 0);
            check("rst_busy", busy, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("warmup_ks_en", ks_en, 1);
        check("warmup_s_ready", s_ready, 0);
        check("warmup_busy", busy, 1);
        repeat (4) @(negedge clk);

        // All-ones keystream: first word 0xFF, so 0x5A decrypts to 0xA5.
        wuc = 1'b1; s_valid = 1'b1; s_data = 8'h5A;
        run_until_accept(edges);
        check("first_ready_edges", edges, DATA_W + 1);
        check("first_m_valid", m_valid, 1);
        check("first_m_data", m_data, 8'hA5);

        // Output stalled: data must hold and the next full word must pause the generator.
        s_data  = 8'h00;
        any_acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("stall_m_data", m_data, 8'hA5);
            step(acc);
            any_acc |= acc;
        end
        check("stall_no_accept", any_acc, 0);
        check("stall_ks_en", ks_en, 0);
        check("stall_s_ready", s_ready, 0);
        check("stall_busy", busy, 1);

        // Drain and accept on the same edge; alternating keystream gives 0x55.
        m_ready = 1'b1;
        step(acc);
        check("drain_accept", acc, 1);
        check("lsb_first_m_valid", m_valid, 1);
        check("lsb_first_m_data", m_data, 8'h55);

        // Drop warm-up after three FILL bits, then re-key the generator.
        s_valid = 1'b0;
        repeat (3) step(acc);
        wuc = 1'b0;
        step(acc);
        check("drop_ks_en", ks_en, 1);
        check("drop_s_ready", s_ready, 0);
        check("drop_m_valid", m_valid, 0);
        for (int i = 0; i < 1024; i++) ks_arr[i] = 1'($urandom_range(1));
        rekey = 1'b1;
        step(acc);
        rekey  = 1'b0;
        word_k = 0;
        repeat (2) step(acc);

        wuc = 1'b1; s_valid = 1'b1; s_data = 8'($urandom);
        run_until_accept(edges);
        check("rewarm_ready_edges", edges, DATA_W + 1);

        // Back-to-back: one word every DATA_W+1 cycles.
        last_cyc = cyc;
        s_data   = 8'($urandom);
        n        = 0;
        for (int c = 0; c < 400 && n < 16; c++) begin
            step(acc);
            if (acc) begin
                n++;
                check("b2b_gap", cyc - last_cyc, DATA_W + 1);
                last_cyc = cyc;
                s_data   = 8'($urandom);
            end
        end
        check("b2b_accepts", n, 16);

        // Random valid/ready pressure on both sides.
        s_valid = 1'b0;
        n       = 0;
        for (int c = 0; c < 5000 && n < 48; c++) begin
            m_ready = ($urandom_range(3) != 0);
            if (!s_valid) begin
                s_valid = ($urandom_range(3) != 0);
                s_data  = 8'($urandom);
            end
            step(acc);
            if (acc) begin
                n++;
                s_valid = 1'b0;
            end
        end
        check("random_accepts", n, 48);

        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) step(acc);
        step(acc);
        check("queue_drained", exp_q.size(), 0);
        check("final_m_valid", m_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
